// File: rtl/led_pkg.sv
// Shared LED animation types: mode encodings seen by the control block, FSM states.
// Pure declarations; no latency, no flow control.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_RUN    = 2'd2,
    MODE_BOUNCE = 2'd3
  } led_mode_t;

  localparam logic [1:0] LED_MODE_OFF    = 2'd0;
  localparam logic [1:0] LED_MODE_BLINK  = 2'd1;
  localparam logic [1:0] LED_MODE_RUN    = 2'd2;
  localparam logic [1:0] LED_MODE_BOUNCE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BLINK  = 3'd1,
    ST_RUN    = 3'd2,
    ST_BOUNCE = 3'd3,
    ST_FLASH  = 3'd4
  } led_state_t;

  function automatic led_state_t mode_state(input led_mode_t m);
    case (m)
      MODE_BLINK:  return ST_BLINK;
      MODE_RUN:    return ST_RUN;
      MODE_BOUNCE: return ST_BOUNCE;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_next.sv
// One animation step for the given mode: combinational, zero latency, no flow control.
// Bounce flips direction on the step that lands on an end bit, so each end shows once.
module led_pattern_next
  import led_pkg::*;
#(
  parameter int LED_WIDTH = 16
) (
  input  logic [LED_WIDTH-1:0] pattern,
  input  led_mode_t            mode,
  input  logic                 dir_down,
  output logic [LED_WIDTH-1:0] pattern_next,
  output logic                 dir_down_next
);

  always_comb begin
    pattern_next  = pattern;
    dir_down_next = dir_down;
    case (mode)
      MODE_BLINK: pattern_next = ~pattern;
      MODE_RUN:   pattern_next = {pattern[LED_WIDTH-2:0], pattern[LED_WIDTH-1]};
      MODE_BOUNCE: begin
        if (!dir_down) begin
          pattern_next = pattern << 1;
          if (pattern_next[LED_WIDTH-1]) dir_down_next = 1'b1;
        end else begin
          pattern_next = pattern >> 1;
          if (pattern_next[0]) dir_down_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/led_pattern_engine.sv
// Tick-driven LED animator (blink/run/bounce) with a retriggerable status flash overlay.
// One-cycle latency from tick/mode_load/flash_req to led; never stalls, ticks during a load or flash request are dropped.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int LED_WIDTH   = 16,
  parameter int FLASH_COUNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [1:0]           mode,
  input  logic                 mode_load,
  input  logic                 flash_req,
  input  logic [LED_WIDTH-1:0] flash_pattern,
  output logic [LED_WIDTH-1:0] led,
  output logic                 busy,
  output logic                 divider_en
);

  localparam int PW = $clog2(2*FLASH_COUNT+1);
  localparam logic [PW-1:0] PHASE_END = PW'(2*FLASH_COUNT);

  led_state_t           state_q, state_nxt;
  led_mode_t            saved_q, saved_nxt;
  logic [LED_WIDTH-1:0] led_q, led_nxt;
  logic [LED_WIDTH-1:0] fpat_q, fpat_nxt;
  logic [PW-1:0]        phase_q, phase_nxt, phase_inc;
  logic                 dir_q, dir_nxt;
  logic                 busy_q, busy_nxt;
  logic [LED_WIDTH-1:0] step_pat;
  logic                 step_dir;
  led_mode_t            mode_in;

  function automatic logic [LED_WIDTH-1:0] init_pattern(input led_mode_t m);
    case (m)
      MODE_OFF:   return '0;
      MODE_BLINK: return '1;
      default:    return LED_WIDTH'(1);
    endcase
  endfunction

  assign mode_in   = led_mode_t'(mode);
  assign phase_inc = phase_q + PW'(1);

  // Outside FLASH the state always mirrors saved_q, so it selects the step.
  led_pattern_next #(.LED_WIDTH(LED_WIDTH)) u_next (
    .pattern       (led_q),
    .mode          (saved_q),
    .dir_down      (dir_q),
    .pattern_next  (step_pat),
    .dir_down_next (step_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      saved_q <= MODE_OFF;
      led_q   <= '0;
      fpat_q  <= '0;
      phase_q <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      saved_q <= saved_nxt;
      led_q   <= led_nxt;
      fpat_q  <= fpat_nxt;
      phase_q <= phase_nxt;
      dir_q   <= dir_nxt;
      busy_q  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    saved_nxt = saved_q;
    led_nxt   = led_q;
    fpat_nxt  = fpat_q;
    phase_nxt = phase_q;
    dir_nxt   = dir_q;
    busy_nxt  = busy_q;

    if (mode_load) saved_nxt = mode_in;

    if (flash_req) begin
      state_nxt = ST_FLASH;
      fpat_nxt  = flash_pattern;
      led_nxt   = flash_pattern;
      phase_nxt = '0;
      busy_nxt  = 1'b1;
    end else if (mode_load) begin
      if (state_q != ST_FLASH) begin
        state_nxt = mode_state(mode_in);
        led_nxt   = init_pattern(mode_in);
        dir_nxt   = 1'b0;
      end
    end else if (tick) begin
      if (state_q == ST_FLASH) begin
        phase_nxt = phase_inc;
        // Odd phases are the dark half of each on/off pair.
        led_nxt   = phase_inc[0] ? '0 : fpat_q;
        if (phase_inc == PHASE_END) begin
          state_nxt = mode_state(saved_q);
          led_nxt   = init_pattern(saved_q);
          dir_nxt   = 1'b0;
          phase_nxt = '0;
          busy_nxt  = 1'b0;
        end
      end else if (state_q != ST_IDLE) begin
        led_nxt = step_pat;
        dir_nxt = step_dir;
      end
    end
  end

  assign led        = led_q;
  assign busy       = busy_q;
  assign divider_en = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed-vector bench for led_pattern_engine at LED_WIDTH=8, FLASH_COUNT=3.
module tb_led_pattern_engine;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [1:0] mode;
  logic       mode_load;
  logic       flash_req;
  logic [7:0] flash_pattern;
  logic [7:0] led;
  logic       busy;
  logic       divider_en;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  led_pattern_engine #(.LED_WIDTH(8), .FLASH_COUNT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .mode          (mode),
    .mode_load     (mode_load),
    .flash_req     (flash_req),
    .flash_pattern (flash_pattern),
    .led           (led),
    .busy          (busy),
    .divider_en    (divider_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; returns #1 after the edge so outputs are settled.
  task automatic cyc(input logic tk, input logic ml, input logic [1:0] md,
                     input logic fr, input logic [7:0] fp);
    tick = tk; mode_load = ml; mode = md; flash_req = fr; flash_pattern = fp;
    @(posedge clk); #1;
    tick = 1'b0; mode_load = 1'b0; flash_req = 1'b0;
  endtask

  task automatic do_tick();
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  task automatic outs(input string tag, input logic [7:0] e_led,
                      input logic e_busy, input logic e_en);
    check({tag, ".led"}, {24'h0, led}, {24'h0, e_led});
    check({tag, ".busy"}, {31'h0, busy}, {31'h0, e_busy});
    check({tag, ".den"}, {31'h0, divider_en}, {31'h0, e_en});
  endtask

  logic [7:0] bounce_exp [16];
  logic [7:0] run_exp;

  initial begin
    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    rst = 1'b1; tick = 1'b0; mode = 2'd0; mode_load = 1'b0;
    flash_req = 1'b0; flash_pattern = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    outs("reset", 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      do_tick();
      outs("idle_tick", 8'h00, 1'b0, 1'b0);
    end

    // RUN: rotate left with wrap
    cyc(1'b0, 1'b1, LED_MODE_RUN, 1'b0, 8'h00);
    outs("run_load", 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      do_tick();
      run_exp = 8'h01 << ((i + 1) % 8);
      check("run_step", {24'h0, led}, {24'h0, run_exp});
    end

    // BOUNCE: each endpoint shown once
    cyc(1'b0, 1'b1, LED_MODE_BOUNCE, 1'b0, 8'h00);
    outs("bounce_load", 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      do_tick();
      check("bounce_step", {24'h0, led}, {24'h0, bounce_exp[i]});
    end

    // BLINK then a full flash
    cyc(1'b0, 1'b1, LED_MODE_BLINK, 1'b0, 8'h00);
    outs("blink_load", 8'hFF, 1'b0, 1'b1);
    do_tick();
    check("blink_step", {24'h0, led}, 32'h00);
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 8'hA5);
    outs("flash_start", 8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      outs("flash_tick", (i % 2 == 0) ? 8'h00 : 8'hA5, 1'b1, 1'b1);
    end
    do_tick();
    outs("flash_exit", 8'hFF, 1'b0, 1'b1);

    // Retrigger mid-flash, and mode_load OFF during the flash
    cyc(1'b0, 1'b0, 2'd0, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) do_tick();
    check("pre_retrig", {24'h0, led}, 32'h00);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 8'h3C);
    outs("retrig", 8'h3C, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, LED_MODE_OFF, 1'b0, 8'h00);
    outs("load_in_flash", 8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      outs("retrig_tick", (i % 2 == 0) ? 8'h00 : 8'h3C, 1'b1, 1'b1);
    end
    do_tick();
    outs("retrig_exit", 8'h00, 1'b0, 1'b0);

    // flash_req together with mode_load: flash wins, saved mode updated
    cyc(1'b1, 1'b1, LED_MODE_BLINK, 1'b1, 8'h0F);
    outs("flash_and_load", 8'h0F, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) do_tick();
    check("fl_last_off", {24'h0, led}, 32'h00);
    do_tick();
    outs("fl_exit_blink", 8'hFF, 1'b0, 1'b1);

    // tick coincident with mode_load is dropped
    cyc(1'b1, 1'b1, LED_MODE_RUN, 1'b0, 8'h00);
    outs("tick_drop", 8'h01, 1'b0, 1'b1);
    do_tick();
    check("run_after_drop", {24'h0, led}, 32'h02);

    // Reset mid-BOUNCE
    cyc(1'b0, 1'b1, LED_MODE_BOUNCE, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) do_tick();
    check("bounce_mid", {24'h0, led}, 32'h08);
    rst = 1'b1;
    do_tick();
    rst = 1'b0;
    outs("mid_reset", 8'h00, 1'b0, 1'b0);
    check("state_idle", {29'h0, dut.state_q}, {29'h0, ST_IDLE});
    do_tick();
    outs("post_reset_tick", 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Downstream consumer of the LED clock divider's `tick` strobe: turns each tick into one step of a selectable LED animation (blink, running light, bounce) and overlays a retriggerable status flash. Sits between the divider and the board LED pins. Gates the divider through `divider_en` so the divider idles when nothing animates.

## Interface
- `LED_WIDTH`, 16: number of LEDs driven; legal range ≥ 2.
- `FLASH_COUNT`, 3: on/off pairs per status flash; legal range ≥ 1.

- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle strobe from clock_divider; one animation step per tick.
- `mode` in 2: 0 OFF, 1 BLINK, 2 RUN, 3 BOUNCE; sampled only when `mode_load`=1.
- `mode_load` in 1: one-cycle pulse; latches `mode` and restarts its pattern.
- `flash_req` in 1: one-cycle pulse; starts or retriggers the status flash.
- `flash_pattern` in LED_WIDTH: pattern shown during flash "on" phases; sampled with `flash_req`.
- `led` out LED_WIDTH: registered LED drive.
- `busy` out 1: registered; high while flashing.
- `divider_en` out 1: enable to clock_divider; low only in OFF with no flash.

## Operation
- States: IDLE (mode OFF), BLINK, RUN, BOUNCE, FLASH. `saved_mode` holds the last loaded mode.
- Initial pattern on entering a mode: OFF all-0; BLINK all-1; RUN `0…01`; BOUNCE `0…01`, direction up.
- Per-tick step:
  - BLINK: `led <= ~led`.
  - RUN: rotate left by 1, MSB wraps into bit 0.
  - BOUNCE: shift left while up; on reaching bit LED_WIDTH-1 the direction flips to down. Shift right while down; on reaching bit 0 the direction flips to up. The endpoint is shown for one tick only.
  - Period is 2·(LED_WIDTH-1). For width 4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, …
  - OFF: ticks ignored.
- FLASH:
  - On entry, latch `flash_pattern`, set `led` to it, clear the phase counter.
  - Each tick toggles `led` between the latched pattern and 0 and increments the phase counter.
  - On the 2·FLASH_COUNT-th tick, exit to `saved_mode` with that mode's initial pattern, not the pre-flash position.
- Priorities in the same cycle:
  - `flash_req` over `mode_load` over `tick`.
  - `mode_load` with `flash_req`: update `saved_mode`, enter FLASH.
  - `mode_load` while in FLASH: update `saved_mode` only; the flash continues.
  - `flash_req` while in FLASH: re-latch the pattern, reset the phase counter to 0, set `led` to the new pattern.
  - `tick` coincident with `mode_load` or `flash_req`: dropped.
- `divider_en` is combinational from state: 0 in IDLE, 1 otherwise.
- Reset: state IDLE, `saved_mode` OFF, `led` 0, `busy` 0, `divider_en` 0, direction up, phase counter 0. Reset mid-flash or mid-animation abandons the operation fully.
- Phase counter width: `$clog2(2*FLASH_COUNT+1)`. No wrap is possible because exit occurs at the terminal count.

## Timing
- `mode_load` at cycle N: new initial pattern on `led` at N+1.
- `tick` at cycle N: stepped pattern on `led` at N+1.
- `flash_req` at cycle N: `led` equals `flash_pattern` and `busy`=1 at N+1.
- Final flash tick at cycle N: `busy`=0 and `led` holds the `saved_mode` initial pattern at N+1.
- `divider_en` follows state with the same one-cycle latency as `led`.
- `tick` is assumed to be a single-cycle strobe. Back-to-back ticks on consecutive cycles are legal, and each advances one step.

## Structure
- Shared package `led_pkg`:
  - `led_mode_t` enum (OFF/BLINK/RUN/BOUNCE, 2 bits).
  - `led_state_t` enum (IDLE/BLINK/RUN/BOUNCE/FLASH).
  - Mode encoding constants, shared with the top-level control that drives `mode`.
- One combinational sub-module `led_pattern_next`:
  - Inputs: current pattern, mode, direction.
  - Outputs: next pattern, next direction.
  - Keeps the step logic separately testable. The FSM, flash counter and registers stay in `led_pattern_engine`.

## Test plan
All scenarios use LED_WIDTH=8, FLASH_COUNT=3.
- Reset, then idle with ticks: `led`=8'h00, `busy`=0, `divider_en`=0 throughout.
- `mode_load` RUN then 9 ticks → `led`=01, 02, 04, …, 80, 01, 02. `divider_en`=1 from the cycle after the load.
- `mode_load` BOUNCE then 16 ticks → 01, 02, 04, 08, 10, 20, 40, 80, 40, 20, 10, 08, 04, 02, 01, 02, 04. Each endpoint appears once per pass.
- In BLINK, `flash_req` with `flash_pattern`=8'hA5 → next cycle `led`=A5, `busy`=1. Ticks give 00, A5, 00, A5, 00, then exit with `led`=FF and `busy`=0.
- Mid-flash (after 3 ticks), `flash_req` with pattern 8'h3C → `led`=3C and a full 6 more ticks are needed before exit. `mode_load` OFF during the flash → exit gives `led`=00 and `divider_en`=0.
- `tick` coincident with `mode_load` RUN → `led`=01 (tick dropped). Assert `rst` mid-BOUNCE → next cycle all outputs 0 and state IDLE.
